key_menu_fsm: RTL and testbench

Clocked successor to the front-panel key controller. Converts five debounced key levels into a registered mode/field state machine for the clock/calendar and for NUM_ALARMS independent alarm channels. Outputs single-cycle UP/DOWN/COMMIT/ABORT/TOGGLE_MERIDIAN strobes plus a field cursor, feeding the time-keeping and alarm-register blocks. Adds programmable edit and view timeouts, and per-alarm enable bits.

---
 rtl/key_menu_fsm.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_key_menu_fsm.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_menu_fsm.sv
// key_menu_fsm -- front-panel key controller for the clock/calendar and its
// alarm channels. Turns five debounced key levels into a registered
// mode/field state machine with single-cycle adjust/commit/abort strobes.
//
// Optional feature macro: AUTO_REPEAT_EN (UP/DOWN auto-repeat while held in
// an edit mode). Without it, each press gives exactly one strobe.
//
// Ports:
//   CLK             in   system clock
//   RESET           in   synchronous, active-high reset
//   KEY[4:0]        in   key levels: [4]MENU [3]SET [2]CANCEL [1]UP [0]DOWN
//   IN_MERIDIAN     in   1 = 12-hour display active (MERIDIAN field exists)
//   MODE[1:0]       out  00 CUR, 01 CUR_EDIT, 10 ALARM_VIEW, 11 ALARM_EDIT
//   FLAG[2:0]       out  000 NO, 001 VIEW_ALARM, 100 EDIT, 101 ALARM_EDIT,
//                        110 DONE, 111 CANCEL
//   CONT[2:0]       out  field cursor (HOUR/MIN/SEC/MERIDIAN/YEAR/MONTH/DAY)
//   ALARM_SEL       out  selected alarm channel
//   ALARM_EN        out  per-alarm armed bits
//   UP_PULSE        out  one-cycle increment strobe for field CONT
//   DOWN_PULSE      out  one-cycle decrement strobe for field CONT
//   COMMIT          out  one-cycle strobe: latch edited value
//   ABORT           out  one-cycle strobe: discard edited value
//   TOGGLE_MERIDIAN out  one-cycle strobe: flip 12/24-hour display
module key_menu_fsm #(
  parameter int unsigned NUM_ALARMS   = 4,
  parameter int unsigned ALARM_W      = 2,
  parameter int unsigned EDIT_TIMEOUT = 1000,
  parameter int unsigned VIEW_TIMEOUT = 300,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [4:0]            KEY,
  input  logic                  IN_MERIDIAN,
  output logic [1:0]            MODE,
  output logic [2:0]            FLAG,
  output logic [2:0]            CONT,
  output logic [ALARM_W-1:0]    ALARM_SEL,
  output logic [NUM_ALARMS-1:0] ALARM_EN,
  output logic                  UP_PULSE,
  output logic                  DOWN_PULSE,
  output logic                  COMMIT,
  output logic                  ABORT,
  output logic                  TOGGLE_MERIDIAN
);

  localparam int unsigned K_MENU   = 4;
  localparam int unsigned K_SET    = 3;
  localparam int unsigned K_CANCEL = 2;
  localparam int unsigned K_UP     = 1;
  localparam int unsigned K_DOWN   = 0;

  localparam logic [2:0] C_NO    = 3'b000;
  localparam logic [2:0] C_HOUR  = 3'b001;
  localparam logic [2:0] C_MIN   = 3'b010;
  localparam logic [2:0] C_SEC   = 3'b011;
  localparam logic [2:0] C_MER   = 3'b100;
  localparam logic [2:0] C_YEAR  = 3'b101;
  localparam logic [2:0] C_MONTH = 3'b110;
  localparam logic [2:0] C_DAY   = 3'b111;

  localparam logic [2:0] F_NO     = 3'b000;
  localparam logic [2:0] F_VIEW   = 3'b001;
  localparam logic [2:0] F_EDIT   = 3'b100;
  localparam logic [2:0] F_AEDIT  = 3'b101;
  localparam logic [2:0] F_DONE   = 3'b110;
  localparam logic [2:0] F_CANCEL = 3'b111;

  // The *_DONE / *_CANC states are the one-cycle DONE/CANCEL flag phase
  // that follows leaving an edit mode; MODE still shows the edit mode.
  typedef enum logic [2:0] {
    S_CUR, S_CEDIT, S_AVIEW, S_AEDIT,
    S_CE_DONE, S_CE_CANC, S_AE_DONE, S_AE_CANC
  } state_e;

  state_e                  state_q, state_d;
  logic [4:0]              key_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic [2:0]              flag_q, flag_d;
  logic [2:0]              cont_q, cont_d;
  logic [ALARM_W-1:0]      sel_q, sel_d;
  logic [NUM_ALARMS-1:0]   en_q, en_d;
  logic                    up_q, up_d, dn_q, dn_d;
  logic                    commit_q, commit_d, abort_q, abort_d, tog_q, tog_d;

  logic [4:0]              press;
  logic                    key_ok, edit_to, view_to, rep_fire, counting, do_set;
  logic [NUM_ALARMS-1:0]   sel_oh;

  assign press   = KEY & ~key_q;
  // Only a single new press with no other key held is a command.
  assign key_ok  = $onehot(press) && $onehot(KEY);
  assign edit_to = (cnt_q == CNT_W'(EDIT_TIMEOUT - 1));
  assign view_to = (cnt_q == CNT_W'(VIEW_TIMEOUT - 1));
  assign counting = (state_q == S_CEDIT) || (state_q == S_AVIEW) || (state_q == S_AEDIT);

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             hold_ok;

  // rep_q counts held cycles; after a repeat it is reloaded so the next
  // repeat lands REPEAT_RATE cycles later using the same compare value.
  assign hold_ok  = (KEY == key_q) && ((KEY == 5'b00010) || (KEY == 5'b00001)) &&
                    ((state_q == S_CEDIT) || (state_q == S_AEDIT));
  assign rep_fire = hold_ok && (rep_q == CNT_W'(REPEAT_DELAY - 1));

  always_comb begin
    rep_d = '0;
    if (hold_ok) rep_d = rep_fire ? CNT_W'(REPEAT_DELAY - REPEAT_RATE) : rep_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  function automatic logic [2:0] next_cur(input logic [2:0] c, input logic im);
    case (c)
      C_HOUR:  next_cur = C_MIN;
      C_MIN:   next_cur = C_SEC;
      C_SEC:   next_cur = im ? C_MER : C_YEAR;
      C_MER:   next_cur = C_YEAR;
      C_YEAR:  next_cur = C_MONTH;
      C_MONTH: next_cur = C_DAY;
      default: next_cur = C_HOUR;
    endcase
  endfunction

  function automatic logic [2:0] next_alarm(input logic [2:0] c, input logic im);
    case (c)
      C_HOUR:  next_alarm = C_MIN;
      C_MIN:   next_alarm = im ? C_MER : C_HOUR;
      default: next_alarm = C_HOUR;
    endcase
  endfunction

  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++)
      if (ALARM_W'(i) == sel_q) sel_oh[i] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    sel_d    = sel_q;
    en_d     = en_q;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    commit_d = 1'b0;
    abort_d  = 1'b0;
    tog_d    = 1'b0;
    do_set   = 1'b0;
    mode_d   = 2'b00;
    flag_d   = F_NO;
    cnt_d    = '0;

    case (state_q)
      S_CUR: begin
        if (key_ok) begin
          if (KEY[K_MENU]) begin
            state_d = S_AVIEW;
            sel_d   = '0;
          end else if (KEY[K_SET]) begin
            state_d = S_CEDIT;
            cont_d  = C_HOUR;
          end else if (KEY[K_CANCEL]) begin
            tog_d = 1'b1;
          end
        end
      end
      S_CEDIT, S_AEDIT: begin
        if (key_ok) begin
          if (KEY[K_MENU])
            cont_d = (state_q == S_CEDIT) ? next_cur(cont_q, IN_MERIDIAN)
                                          : next_alarm(cont_q, IN_MERIDIAN);
          else if (KEY[K_UP])   up_d = 1'b1;
          else if (KEY[K_DOWN]) dn_d = 1'b1;
          else if (KEY[K_SET])  do_set = 1'b1;
          else begin
            abort_d = 1'b1;
            state_d = (state_q == S_CEDIT) ? S_CE_CANC : S_AE_CANC;
          end
        end else if (rep_fire) begin
          up_d = KEY[K_UP];
          dn_d = KEY[K_DOWN];
        end else if (edit_to) begin
          do_set = 1'b1;
        end
        if (do_set) begin
          commit_d = 1'b1;
          if (state_q == S_CEDIT) begin
            state_d = S_CE_DONE;
          end else begin
            state_d = S_AE_DONE;
            en_d    = en_q | sel_oh;
          end
        end
      end
      S_AVIEW: begin
        if (key_ok) begin
          if (KEY[K_MENU]) begin
            if (sel_q == ALARM_W'(NUM_ALARMS - 1)) begin
              state_d = S_CUR;
              sel_d   = '0;
            end else begin
              sel_d = sel_q + ALARM_W'(1);
            end
          end else if (KEY[K_SET]) begin
            state_d = S_AEDIT;
            cont_d  = C_HOUR;
          end else if (KEY[K_CANCEL]) begin
            en_d = en_q ^ sel_oh;
          end
        end else if (view_to) begin
          state_d = S_CUR;
          sel_d   = '0;
        end
      end
      S_CE_DONE, S_CE_CANC: begin
        state_d = S_CUR;
        cont_d  = C_NO;
      end
      default: begin
        state_d = S_AVIEW;
        cont_d  = C_NO;
      end
    endcase

    // Registered MODE/FLAG are a pure decode of the next state.
    case (state_d)
      S_CUR:     begin mode_d = 2'b00; flag_d = F_NO;     end
      S_CEDIT:   begin mode_d = 2'b01; flag_d = F_EDIT;   end
      S_AVIEW:   begin mode_d = 2'b10; flag_d = F_VIEW;   end
      S_AEDIT:   begin mode_d = 2'b11; flag_d = F_AEDIT;  end
      S_CE_DONE: begin mode_d = 2'b01; flag_d = F_DONE;   end
      S_CE_CANC: begin mode_d = 2'b01; flag_d = F_CANCEL; end
      S_AE_DONE: begin mode_d = 2'b11; flag_d = F_DONE;   end
      default:   begin mode_d = 2'b11; flag_d = F_CANCEL; end
    endcase

    // A press (or repeat) beats a same-cycle timeout and restarts the count.
    if (counting && !key_ok && !rep_fire && (state_d == state_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_CUR;
      key_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 2'b00;
      flag_q   <= F_NO;
      cont_q   <= C_NO;
      sel_q    <= '0;
      en_q     <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      commit_q <= 1'b0;
      abort_q  <= 1'b0;
      tog_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= KEY;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      flag_q   <= flag_d;
      cont_q   <= cont_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      commit_q <= commit_d;
      abort_q  <= abort_d;
      tog_q    <= tog_d;
    end
  end

  assign MODE            = mode_q;
  assign FLAG            = flag_q;
  assign CONT            = cont_q;
  assign ALARM_SEL       = sel_q;
  assign ALARM_EN        = en_q;
  assign UP_PULSE        = up_q;
  assign DOWN_PULSE      = dn_q;
  assign COMMIT          = commit_q;
  assign ABORT           = abort_q;
  assign TOGGLE_MERIDIAN = tog_q;

endmodule

// File: tb/tb_key_menu_fsm.sv
module tb_key_menu_fsm;

  localparam int unsigned NA = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned ET = 1000;
  localparam int unsigned VT = 300;
  localparam int unsigned RD = 500;
  localparam int unsigned RR = 100;

  localparam logic [4:0] K_MENU   = 5'b10000;
  localparam logic [4:0] K_SET    = 5'b01000;
  localparam logic [4:0] K_CANCEL = 5'b00100;
  localparam logic [4:0] K_UP     = 5'b00010;
  localparam logic [4:0] K_DOWN   = 5'b00001;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [4:0]    KEY;
  logic          IN_MERIDIAN;
  logic [1:0]    MODE;
  logic [2:0]    FLAG;
  logic [2:0]    CONT;
  logic [AW-1:0] ALARM_SEL;
  logic [NA-1:0] ALARM_EN;
  logic          UP_PULSE, DOWN_PULSE, COMMIT, ABORT, TOGGLE_MERIDIAN;

  key_menu_fsm #(
    .NUM_ALARMS(NA), .ALARM_W(AW), .EDIT_TIMEOUT(ET), .VIEW_TIMEOUT(VT),
    .CNT_W(16), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLK(CLK), .RESET(RESET), .KEY(KEY), .IN_MERIDIAN(IN_MERIDIAN),
    .MODE(MODE), .FLAG(FLAG), .CONT(CONT), .ALARM_SEL(ALARM_SEL),
    .ALARM_EN(ALARM_EN), .UP_PULSE(UP_PULSE), .DOWN_PULSE(DOWN_PULSE),
    .COMMIT(COMMIT), .ABORT(ABORT), .TOGGLE_MERIDIAN(TOGGLE_MERIDIAN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cycles   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycles);
    end
  endtask

  // Reference model: menu position as plain integers, timeouts as a count
  // of idle cycles since the last activity.
  int         m_mode, m_flag, m_cont, m_sel, m_idle, m_hold;
  logic [NA-1:0] m_en;
  bit         m_up, m_dn, m_commit, m_abort, m_tog, m_end;
  logic [4:0] m_prev;

  function automatic int next_field(input int cur, input bit alarm, input bit im);
    int ord[$];
    int n;
    if (alarm) ord = '{1, 2, 4};
    else       ord = '{1, 2, 3, 4, 5, 6, 7};
    n = ord.size();
    for (int i = 0; i < n; i++) begin
      if (ord[i] == cur) begin
        if (ord[(i + 1) % n] == 4 && !im) return ord[(i + 2) % n];
        return ord[(i + 1) % n];
      end
    end
    return 1;
  endfunction

  task automatic finish_edit(input bit keep);
    if (keep) begin
      m_commit = 1;
      m_flag   = 6;
      if (m_mode == 3) m_en[m_sel] = 1'b1;
    end else begin
      m_abort = 1;
      m_flag  = 7;
    end
    m_end  = 1;
    m_idle = 0;
  endtask

  task automatic model_press(input logic [4:0] pr, input bit im);
    case (m_mode)
      0: begin
        if (pr == K_MENU)        begin m_mode = 2; m_flag = 1; m_sel = 0; end
        else if (pr == K_SET)    begin m_mode = 1; m_flag = 4; m_cont = 1; end
        else if (pr == K_CANCEL) m_tog = 1;
      end
      2: begin
        if (pr == K_MENU) begin
          if (m_sel == int'(NA) - 1) begin m_mode = 0; m_flag = 0; m_sel = 0; end
          else m_sel++;
        end else if (pr == K_SET) begin
          m_mode = 3; m_flag = 5; m_cont = 1;
        end else if (pr == K_CANCEL) begin
          m_en[m_sel] = ~m_en[m_sel];
        end
      end
      default: begin
        if (pr == K_MENU)        m_cont = next_field(m_cont, m_mode == 3, im);
        else if (pr == K_UP)     m_up = 1;
        else if (pr == K_DOWN)   m_dn = 1;
        else if (pr == K_SET)    finish_edit(1);
        else                     finish_edit(0);
      end
    endcase
  endtask

  task automatic model_step(input logic [4:0] k, input bit im, input bit rst);
    logic [4:0] pr;
    bit acc, held, fire;
    m_up = 0; m_dn = 0; m_commit = 0; m_abort = 0; m_tog = 0;
    if (rst) begin
      m_mode = 0; m_flag = 0; m_cont = 0; m_sel = 0; m_en = '0;
      m_idle = 0; m_hold = 0; m_end = 0; m_prev = '0;
      return;
    end
    pr   = k & ~m_prev;
    acc  = ($countones(pr) == 1) && ($countones(k) == 1);
    held = (k == m_prev) && (k == K_UP || k == K_DOWN) && (m_mode % 2 == 1) && !m_end;
    m_prev = k;
    m_hold = held ? m_hold + 1 : 0;
    if (m_end) begin
      m_end = 0; m_cont = 0; m_idle = 0;
      if (m_mode == 1) begin m_mode = 0; m_flag = 0; end
      else             begin m_mode = 2; m_flag = 1; end
      return;
    end
    if (acc) begin
      m_idle = 0;
      model_press(pr, im);
      return;
    end
    if (m_mode != 0) m_idle++;
    fire = 0;
`ifdef AUTO_REPEAT_EN
    fire = held && (m_hold >= int'(RD)) && ((m_hold - int'(RD)) % int'(RR) == 0);
`endif
    if (fire) begin
      m_idle = 0;
      m_up   = (k == K_UP);
      m_dn   = (k == K_DOWN);
    end else if (m_mode % 2 == 1 && m_idle == int'(ET)) begin
      finish_edit(1);
    end else if (m_mode == 2 && m_idle == int'(VT)) begin
      m_mode = 0; m_flag = 0; m_sel = 0; m_idle = 0;
    end
  endtask

  function automatic logic [31:0] model_vec();
    return 32'({2'(m_mode), 3'(m_flag), 3'(m_cont), AW'(m_sel), m_en,
                m_up, m_dn, m_commit, m_abort, m_tog});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({MODE, FLAG, CONT, ALARM_SEL, ALARM_EN,
                UP_PULSE, DOWN_PULSE, COMMIT, ABORT, TOGGLE_MERIDIAN});
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step(KEY, IN_MERIDIAN, RESET);
    cycles++;
    #1;
    check("outputs", dut_vec(), model_vec());
  endtask

  task automatic press(input logic [4:0] k);
    KEY = k;
    tick();
  endtask

  task automatic rel();
    KEY = '0;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    KEY   = '0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    int pulses[$];
    int exp_p[$];
    bit seen;

    RESET = 1'b1;
    KEY = '0;
    IN_MERIDIAN = 1'b1;
    do_reset();
    check("reset_state", dut_vec(), 32'd0);

    // Reset in the middle of an edit.
    press(K_SET); rel(); press(K_UP); rel();
    check("pre_reset_mode", 32'(MODE), 32'd1);
    seen = 0;
    RESET = 1'b1;
    tick(); seen |= COMMIT | ABORT;
    tick(); seen |= COMMIT | ABORT;
    check("reset_outputs", dut_vec(), 32'd0);
    RESET = 1'b0;
    tick(); seen |= COMMIT | ABORT;
    check("no_commit_abort_on_reset", 32'(seen), 32'd0);

    // Clock edit walk with 24-hour display.
    IN_MERIDIAN = 1'b0;
    press(K_SET);  check("edit_cont_hour", 32'(CONT), 32'd1); check("edit_flag", 32'(FLAG), 32'd4); rel();
    press(K_MENU); check("cont_min", 32'(CONT), 32'd2); rel();
    press(K_MENU); check("cont_sec", 32'(CONT), 32'd3); rel();
    press(K_MENU); check("cont_year_skip_mer", 32'(CONT), 32'd5); rel();
    press(K_UP);   check("up_pulse", 32'(UP_PULSE), 32'd1); check("up_cont", 32'(CONT), 32'd5);
    rel();         check("up_one_cycle", 32'(UP_PULSE), 32'd0);
    press(K_SET);  check("commit", 32'(COMMIT), 32'd1); check("flag_done", 32'(FLAG), 32'd6);
    rel();         check("commit_one_cycle", 32'(COMMIT), 32'd0);
    check("flag_after_done", 32'(FLAG), 32'd0); check("mode_cur", 32'(MODE), 32'd0);
    IN_MERIDIAN = 1'b1;

    // Alarm view stepping and enable toggle.
    for (int i = 0; i < int'(NA); i++) begin
      press(K_MENU);
      check("view_mode", 32'(MODE), 32'd2);
      check("view_sel", 32'(ALARM_SEL), 32'(i));
      rel();
    end
    press(K_MENU); check("view_wrap_mode", 32'(MODE), 32'd0); check("view_wrap_sel", 32'(ALARM_SEL), 32'd0); rel();
    press(K_MENU); rel(); press(K_MENU); rel(); press(K_MENU); rel();
    press(K_CANCEL); check("alarm_en_toggle", 32'(ALARM_EN), 32'b0100); rel();

    // Alarm edit timeout followed by view timeout.
    do_reset();
    press(K_MENU); rel(); press(K_MENU); rel();
    press(K_SET);  check("aedit_mode", 32'(MODE), 32'd3);
    KEY = '0;
    n = 0;
    do begin tick(); n++; end while (!COMMIT && n < int'(ET) + 100);
    check("edit_timeout_cycle", 32'(n), 32'(ET));
    check("timeout_en", 32'(ALARM_EN), 32'b0010);
    check("timeout_flag", 32'(FLAG), 32'd6);
    tick();
    check("back_to_view", 32'(MODE), 32'd2);
    check("back_flag", 32'(FLAG), 32'd1);
    n = 1;
    do begin tick(); n++; end while (MODE != 2'b00 && n < int'(VT) + 100);
    check("view_timeout_cycle", 32'(n), 32'(VT + 1));

    // Multi-key press and key during the DONE flag cycle.
    do_reset();
    KEY = K_MENU | K_SET; tick(); check("multi_key_ignored", dut_vec(), 32'd0); rel();
    press(K_SET); rel();
    press(K_SET); check("done_flag", 32'(FLAG), 32'd6);
    KEY = K_CANCEL; tick();
    check("cancel_in_done_mode", 32'(MODE), 32'd0);
    check("cancel_in_done_strobes", 32'({ABORT, TOGGLE_MERIDIAN}), 32'd0);
    rel();

    // Holding UP in clock edit.
    do_reset();
    press(K_SET); rel();
    KEY = K_UP;
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (UP_PULSE) pulses.push_back(i);
    end
    check("hold_mode", 32'(MODE), 32'd1);
    exp_p.push_back(1);
`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < 3; i++) exp_p.push_back(int'(RD + RR * i) + 1);
`endif
    check("hold_pulse_count", 32'(pulses.size()), 32'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && i < pulses.size(); i++)
      check("hold_pulse_at", 32'(pulses[i]), 32'(exp_p[i]));
    rel();

    // Randomized key traffic against the model.
    do_reset();
    while (cycles < 45000) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        KEY = 5'b00001 << $urandom_range(0, 4);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) tick();
        KEY = '0;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) tick();
      end else if (r < 70) begin
        KEY = 5'($urandom_range(0, 31));
        tick();
        rel();
      end else if (r < 80) begin
        KEY = '0;
        n = $urandom_range(0, 200);
        for (int i = 0; i < n; i++) tick();
      end else if (r < 85) begin
        KEY = '0;
        n = $urandom_range(290, 1050);
        for (int i = 0; i < n; i++) tick();
      end else if (r < 93) begin
        IN_MERIDIAN = ~IN_MERIDIAN;
        tick();
      end else if (r < 98) begin
        KEY = 5'b00001 << $urandom_range(0, 4);
        tick();
      end else begin
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        KEY = '0;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
